// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   General-purpose register file with a per-register pending-write
//   scoreboard. One synchronous write port, two combinational read ports
//   with same-cycle write bypass, optional hard-wired zero register, and a
//   registered debug tap.
//
//   Each register has a saturating outstanding-claim counter. Decode claims
//   a destination through claim_en/claim_addr, writeback retires it through
//   wr_en/wr_addr, and each read port reports whether its operand is still
//   pending.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   wr_en/wr_addr/wr_data    writeback
//   claim_en/claim_addr      decode destination claim
//   claim_ok                 claim accepted this cycle (combinational)
//   rd_addrN/rd_dataN        read ports, combinational, write-bypassed
//   rd_busyN                 operand still pending on read port N
//   dbg_sel/dbg_out          registered, write-bypassed debug view
module regfile_scoreboard #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 3,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              claim_en,
   input  logic [ADDR_W-1:0] claim_addr,
   output logic              claim_ok,
   input  logic [ADDR_W-1:0] rd_addr1,
   output logic [DATA_W-1:0] rd_data1,
   output logic              rd_busy1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data2,
   output logic              rd_busy2,
   input  logic [ADDR_W-1:0] dbg_sel,
   output logic [DATA_W-1:0] dbg_out
);

   localparam int              NREGS = 2**ADDR_W;
   localparam logic [CNT_W-1:0] CMAX = '1;

   logic [DATA_W-1:0] regs [NREGS];
   logic [CNT_W-1:0]  cnt  [NREGS];

   // Writes are ignored during reset, so the bypass and retirement paths
   // must ignore them as well to stay consistent with the stored state.
   logic wr_act;
   assign wr_act = wr_en & ~rst;

   function automatic logic is_zero(input logic [ADDR_W-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   // Retirement of a register this cycle: a write to a register with an
   // outstanding claim. Writes to unclaimed registers never decrement.
   function automatic logic retire(input logic [ADDR_W-1:0] a);
      return wr_act && (wr_addr == a) && (cnt[a] != '0);
   endfunction

   function automatic logic [DATA_W-1:0] rd_val(input logic [ADDR_W-1:0] a);
      if (is_zero(a))
         return '0;
      else if (wr_act && (wr_addr == a))
         return wr_data;
      else
         return regs[a];
   endfunction

   // A same-cycle retirement clears busy together with the bypass; a
   // same-cycle claim only shows up once the counter has moved.
   function automatic logic busy(input logic [ADDR_W-1:0] a);
      if (is_zero(a))
         return 1'b0;
      else
         return (cnt[a] - CNT_W'(retire(a))) != '0;
   endfunction

   logic claim_cnt;

   always_comb begin
      claim_ok  = 1'b0;
      claim_cnt = 1'b0;
      if (claim_en && !rst) begin
         claim_ok  = is_zero(claim_addr) || (cnt[claim_addr] != CMAX) ||
                     retire(claim_addr);
         claim_cnt = claim_ok && !is_zero(claim_addr);
      end
   end

   always_comb begin
      rd_data1 = rd_val(rd_addr1);
      rd_data2 = rd_val(rd_addr2);
      rd_busy1 = busy(rd_addr1);
      rd_busy2 = busy(rd_addr2);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
            cnt[i]  <= '0;
         end
         dbg_out <= '0;
      end else begin
         if (wr_act && !is_zero(wr_addr))
            regs[wr_addr] <= wr_data;
         for (int i = 0; i < NREGS; i++) begin
            cnt[i] <= cnt[i]
                      + CNT_W'(claim_cnt && (claim_addr == ADDR_W'(i)))
                      - CNT_W'(retire(ADDR_W'(i)));
         end
         dbg_out <= rd_val(dbg_sel);
      end
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Directed-vector bench for regfile_scoreboard. Three instances: the
//   default configuration, one with ZERO_REG=0, and a 32-bit x 16 variant.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // default instance: DATA_W=16, ADDR_W=3, ZERO_REG=1, CNT_W=2
   logic        wr_en, claim_en, claim_ok, rd_busy1, rd_busy2;
   logic [2:0]  wr_addr, claim_addr, rd_addr1, rd_addr2, dbg_sel;
   logic [15:0] wr_data, rd_data1, rd_data2, dbg_out;

   regfile_scoreboard u_dut (
      .clk(clk), .rst(rst),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr), .claim_ok(claim_ok),
      .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
      .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
      .dbg_sel(dbg_sel), .dbg_out(dbg_out)
   );

   // ZERO_REG=0 instance
   logic        n_wr_en, n_claim_en, n_claim_ok, n_rd_busy1, n_rd_busy2;
   logic [2:0]  n_wr_addr, n_claim_addr, n_rd_addr1, n_rd_addr2, n_dbg_sel;
   logic [15:0] n_wr_data, n_rd_data1, n_rd_data2, n_dbg_out;

   regfile_scoreboard #(.ZERO_REG(0)) u_dut_nz (
      .clk(clk), .rst(rst),
      .wr_en(n_wr_en), .wr_addr(n_wr_addr), .wr_data(n_wr_data),
      .claim_en(n_claim_en), .claim_addr(n_claim_addr), .claim_ok(n_claim_ok),
      .rd_addr1(n_rd_addr1), .rd_data1(n_rd_data1), .rd_busy1(n_rd_busy1),
      .rd_addr2(n_rd_addr2), .rd_data2(n_rd_data2), .rd_busy2(n_rd_busy2),
      .dbg_sel(n_dbg_sel), .dbg_out(n_dbg_out)
   );

   // wide instance: DATA_W=32, ADDR_W=4
   logic        w_wr_en, w_claim_en, w_claim_ok, w_rd_busy1, w_rd_busy2;
   logic [3:0]  w_wr_addr, w_claim_addr, w_rd_addr1, w_rd_addr2, w_dbg_sel;
   logic [31:0] w_wr_data, w_rd_data1, w_rd_data2, w_dbg_out;

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(4)) u_dut_wide (
      .clk(clk), .rst(rst),
      .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
      .claim_en(w_claim_en), .claim_addr(w_claim_addr), .claim_ok(w_claim_ok),
      .rd_addr1(w_rd_addr1), .rd_data1(w_rd_data1), .rd_busy1(w_rd_busy1),
      .rd_addr2(w_rd_addr2), .rd_data2(w_rd_data2), .rd_busy2(w_rd_busy2),
      .dbg_sel(w_dbg_sel), .dbg_out(w_dbg_out)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs are driven and outputs sampled 1 ns later
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 0; wr_addr = 0; wr_data = 0; claim_en = 0; claim_addr = 0;
      rd_addr1 = 0; rd_addr2 = 0; dbg_sel = 0;
      n_wr_en = 0; n_wr_addr = 0; n_wr_data = 0; n_claim_en = 0;
      n_claim_addr = 0; n_rd_addr1 = 0; n_rd_addr2 = 0; n_dbg_sel = 0;
      w_wr_en = 0; w_wr_addr = 0; w_wr_data = 0; w_claim_en = 0;
      w_claim_addr = 0; w_rd_addr1 = 0; w_rd_addr2 = 0; w_dbg_sel = 0;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      claim_en = 1; claim_addr = 3;
      tick();
      check("claim_ok_in_rst", 32'(claim_ok), 0);
      tick();
      claim_en = 0;
      rst = 0;

      // reset state on every address
      for (int a = 0; a < 8; a++) begin
         rd_addr1 = 3'(a); rd_addr2 = 3'(a); dbg_sel = 3'(a);
         #1;
         check("rst_rd_data1", 32'(rd_data1), 0);
         check("rst_rd_busy1", 32'(rd_busy1), 0);
         check("rst_rd_busy2", 32'(rd_busy2), 0);
         tick();
         check("rst_dbg_out", 32'(dbg_out), 0);
      end

      // write r3, dbg tap sees it one cycle later via bypass
      wr_en = 1; wr_addr = 3; wr_data = 16'hBEEF; dbg_sel = 3;
      tick();
      wr_en = 0; rd_addr1 = 3;
      #1;
      check("r3_readback", 32'(rd_data1), 32'hBEEF);
      check("r3_dbg_out", 32'(dbg_out), 32'hBEEF);

      // same-cycle bypass on both ports
      wr_en = 1; wr_addr = 5; wr_data = 16'h1234; rd_addr1 = 5; rd_addr2 = 5;
      #1;
      check("bypass_p1", 32'(rd_data1), 32'h1234);
      check("bypass_p2", 32'(rd_data2), 32'h1234);
      tick();
      wr_en = 0;
      #1;
      check("r5_stored", 32'(rd_data2), 32'h1234);

      // zero register: write and claim r0
      wr_en = 1; wr_addr = 0; wr_data = 16'hFFFF;
      claim_en = 1; claim_addr = 0; rd_addr1 = 0;
      #1;
      check("r0_claim_ok", 32'(claim_ok), 1);
      check("r0_bypass_zero", 32'(rd_data1), 0);
      tick();
      wr_en = 0; claim_en = 0;
      #1;
      check("r0_data", 32'(rd_data1), 0);
      check("r0_busy", 32'(rd_busy1), 0);

      // saturation on r2
      rd_addr1 = 2;
      for (int k = 0; k < 3; k++) begin
         claim_en = 1; claim_addr = 2;
         #1;
         check("r2_claim_ok", 32'(claim_ok), 1);
         tick();
      end
      check("r2_busy_sat", 32'(rd_busy1), 1);
      check("r2_4th_rejected", 32'(claim_ok), 0);
      tick();
      wr_en = 1; wr_addr = 2; wr_data = 16'h0A0A;
      #1;
      check("r2_claim_with_retire", 32'(claim_ok), 1);
      tick();
      wr_en = 0;
      #1;
      check("r2_still_sat", 32'(claim_ok), 0);
      check("r2_busy_after_swap", 32'(rd_busy1), 1);
      claim_en = 0;
      for (int k = 1; k <= 3; k++) begin
         wr_en = 1; wr_addr = 2; wr_data = 16'(k);
         #1;
         check("r2_busy_during_retire", 32'(rd_busy1), (k == 3) ? 0 : 1);
         check("r2_bypass", 32'(rd_data1), 32'(k));
         tick();
      end
      wr_en = 0;
      #1;
      check("r2_idle_busy", 32'(rd_busy1), 0);
      check("r2_idle_data", 32'(rd_data1), 3);

      // unclaimed write to r6 leaves counter at 0
      wr_en = 1; wr_addr = 6; wr_data = 16'h6666; rd_addr1 = 6;
      tick();
      wr_en = 0;
      #1;
      check("r6_data", 32'(rd_data1), 32'h6666);
      check("r6_busy", 32'(rd_busy1), 0);
      claim_en = 1; claim_addr = 6;
      tick();
      claim_en = 0;
      #1;
      check("r6_busy_one_claim", 32'(rd_busy1), 1);
      wr_en = 1; wr_addr = 6; wr_data = 16'h6667;
      #1;
      check("r6_single_retire", 32'(rd_busy1), 0);
      tick();
      wr_en = 0;

      // claim+write r4 from cnt=1 keeps it pending
      rd_addr1 = 4; claim_en = 1; claim_addr = 4;
      tick();
      wr_en = 1; wr_addr = 4; wr_data = 16'h4444;
      #1;
      check("r4_claim_ok", 32'(claim_ok), 1);
      tick();
      wr_en = 0; claim_en = 0;
      #1;
      check("r4_busy_kept", 32'(rd_busy1), 1);
      wr_en = 1; wr_addr = 4; wr_data = 16'h4445;
      tick();
      wr_en = 0;
      #1;
      check("r4_busy_clear", 32'(rd_busy1), 0);

      // ZERO_REG=0: r0 is an ordinary register
      n_wr_en = 1; n_wr_addr = 0; n_wr_data = 16'hFFFF;
      n_claim_en = 1; n_claim_addr = 0; n_rd_addr1 = 0;
      #1;
      check("nz_r0_claim_ok", 32'(n_claim_ok), 1);
      tick();
      n_wr_en = 0; n_claim_en = 0;
      #1;
      check("nz_r0_data", 32'(n_rd_data1), 32'hFFFF);
      check("nz_r0_busy", 32'(n_rd_busy1), 1);

      // wide variant on r15
      w_rd_addr1 = 15; w_rd_addr2 = 15;
      #1;
      check("wide_r15_rst", w_rd_data1, 0);
      check("wide_r15_busy", 32'(w_rd_busy1), 0);
      w_wr_en = 1; w_wr_addr = 15; w_wr_data = 32'hDEADBEEF;
      #1;
      check("wide_bypass", w_rd_data2, 32'hDEADBEEF);
      tick();
      w_wr_en = 0;
      #1;
      check("wide_r15_data", w_rd_data1, 32'hDEADBEEF);

      // reset discards outstanding claims on r1
      wr_en = 1; wr_addr = 1; wr_data = 16'h1111;
      tick();
      wr_en = 0; claim_en = 1; claim_addr = 1; rd_addr1 = 1; dbg_sel = 1;
      tick();
      tick();
      claim_en = 0;
      #1;
      check("r1_busy_pre_rst", 32'(rd_busy1), 1);
      rst = 1;
      tick();
      rst = 0;
      #1;
      check("r1_busy_post_rst", 32'(rd_busy1), 0);
      check("r1_data_post_rst", 32'(rd_data1), 0);
      check("dbg_post_rst", 32'(dbg_out), 0);
      check("wide_post_rst", w_rd_data1, 0);
      claim_en = 1; claim_addr = 1;
      #1;
      check("r1_claim_post_rst", 32'(claim_ok), 1);
      tick();
      claim_en = 0;
      #1;
      check("r1_busy_new_claim", 32'(rd_busy1), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
